// File: rtl/exhaustive_sweep_engine.sv
// rtl/exhaustive_sweep_engine.sv - applies every IN_W-bit pattern to an external DUT, records responses, counts ones, builds a signature
module exhaustive_sweep_engine #(
  parameter int IN_W   = 4,
  parameter int OUT_W  = 1,
  parameter int SETTLE = 1,
  parameter int GRAY   = 0
) (
  input  logic              CK,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  output logic [IN_W-1:0]   pat_out,
  input  logic [OUT_W-1:0]  dut_resp,
  output logic              busy,
  output logic              done,
  input  logic [IN_W-1:0]   rd_addr,
  output logic [OUT_W-1:0]  rd_data,
  output logic [IN_W:0]     ones_cnt,
  output logic [15:0]       sig
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

  localparam logic [IN_W-1:0] IDX_LAST    = '1;
  localparam logic [3:0]      SETTLE_LAST = 4'(SETTLE - 1);

  state_t             state_q, state_d;
  logic [IN_W-1:0]    idx_q, idx_d;
  logic [IN_W-1:0]    pat_q, pat_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [IN_W:0]      ones_q, ones_d;
  logic [15:0]        sig_q, sig_d;
  logic [OUT_W-1:0]   rd_data_q, rd_data_d;
  logic               wr_en;
  logic [OUT_W-1:0]   mem [0:(1<<IN_W)-1];

  function automatic logic [IN_W-1:0] code(input logic [IN_W-1:0] v);
    if (GRAY != 0) return v ^ (v >> 1);
    return v;
  endfunction

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pat_d     = pat_q;
    cnt_d     = cnt_q;
    ones_d    = ones_q;
    sig_d     = sig_q;
    wr_en     = 1'b0;
    rd_data_d = mem[rd_addr];
    case (state_q)
      S_IDLE: begin
        if (start) begin
          idx_d   = '0;
          ones_d  = '0;
          sig_d   = '0;
          pat_d   = code('0);
          state_d = S_APPLY;
        end
      end
      S_APPLY: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (SETTLE > 0) begin
          cnt_d   = 4'd0;
          state_d = S_SETTLE;
        end else begin
          state_d = S_SAMPLE;
        end
      end
      S_SETTLE: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (cnt_q == SETTLE_LAST) begin
          state_d = S_SAMPLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_SAMPLE: begin
        // an abort here drops the write and leaves the counters untouched
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          wr_en = 1'b1;
          if (dut_resp != '0) ones_d = ones_q + (IN_W+1)'(1);
          sig_d = {sig_q[14:0], sig_q[15] ^ sig_q[13] ^ sig_q[12] ^ sig_q[10]} ^ 16'(dut_resp);
          if (idx_q == IDX_LAST) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + IN_W'(1);
            pat_d   = code(idx_q + IN_W'(1));
            state_d = S_APPLY;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CK) begin
    if (reset) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      pat_q     <= '0;
      cnt_q     <= 4'd0;
      ones_q    <= '0;
      sig_q     <= '0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      pat_q     <= pat_d;
      cnt_q     <= cnt_d;
      ones_q    <= ones_d;
      sig_q     <= sig_d;
      rd_data_q <= rd_data_d;
    end
  end

  // response memory is deliberately not reset
  always_ff @(posedge CK) begin
    if (wr_en && !reset) mem[pat_q] <= dut_resp;
  end

  assign pat_out  = pat_q;
  assign busy     = (state_q == S_APPLY) || (state_q == S_SETTLE) || (state_q == S_SAMPLE);
  assign done     = (state_q == S_DONE);
  assign rd_data  = rd_data_q;
  assign ones_cnt = ones_q;
  assign sig      = sig_q;

endmodule

// File: tb/tb_exhaustive_sweep_engine.sv
// tb/tb_exhaustive_sweep_engine.sv - directed bench for exhaustive_sweep_engine (default and GRAY=1/SETTLE=0 instances)
module tb_exhaustive_sweep_engine;

  logic       CK = 1'b0;
  logic       reset, start, abort, start_g, abort_g, resp_zero;
  logic [3:0] rd_addr;

  logic [3:0] pat_out, pat_out_g;
  logic       busy, done, busy_g, done_g;
  logic [0:0] dut_resp, dut_resp_g, rd_data, rd_data_g;
  logic [4:0] ones_cnt, ones_cnt_g;
  logic [15:0] sig, sig_g;

  int total = 0;
  int bad   = 0;
  int done_g_cyc;
  int dc, dn;
  int gexp [0:8] = '{0, 1, 3, 2, 6, 7, 5, 4, 12};

  always #5 CK = ~CK;

  assign dut_resp   = resp_zero ? 1'b0 : &pat_out;
  assign dut_resp_g = &pat_out_g;

  exhaustive_sweep_engine u_dut (
    .CK(CK), .reset(reset), .start(start), .abort(abort),
    .pat_out(pat_out), .dut_resp(dut_resp), .busy(busy), .done(done),
    .rd_addr(rd_addr), .rd_data(rd_data), .ones_cnt(ones_cnt), .sig(sig)
  );

  exhaustive_sweep_engine #(.IN_W(4), .OUT_W(1), .SETTLE(0), .GRAY(1)) u_dut_g (
    .CK(CK), .reset(reset), .start(start_g), .abort(abort_g),
    .pat_out(pat_out_g), .dut_resp(dut_resp_g), .busy(busy_g), .done(done_g),
    .rd_addr(rd_addr), .rd_data(rd_data_g), .ones_cnt(ones_cnt_g), .sig(sig_g)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge CK);
    #1;
  endtask

  // cycle 0 is the cycle in which start is sampled; loop body runs in cycle c
  task automatic sweep(input int abort_at, input int reset_at, input bit chk_pat,
                       input bit with_g, input bit chk_rdw,
                       output int done_cyc, output int done_n);
    done_cyc = -1;
    done_n   = 0;
    start    = 1'b1;
    start_g  = with_g;
    tick;
    start    = 1'b0;
    start_g  = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      if (done) begin
        done_n++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (with_g && done_g && done_g_cyc < 0) done_g_cyc = c;
      if (chk_pat && c <= 48) check_eq($sformatf("pat_c%0d", c), pat_out, (c - 1) / 3);
      if (with_g && c <= 18) check_eq($sformatf("gray_pat_c%0d", c), pat_out_g, gexp[(c - 1) / 2]);
      if (chk_rdw && c == 49) check_eq("rd_old_data", rd_data, 1);
      if (chk_rdw && c == 50) check_eq("rd_new_data", rd_data, 0);
      if (chk_pat && (c == 5 || c == 49)) start = 1'b1;
      if (c == abort_at) abort = 1'b1;
      if (c == reset_at) reset = 1'b1;
      tick;
      start = 1'b0;
      abort = 1'b0;
      if (c == abort_at) check_eq("busy_after_abort", busy, 0);
      if (c == reset_at) begin
        check_eq("rst_mid_pat", pat_out, 0);
        check_eq("rst_mid_busy", busy, 0);
        check_eq("rst_mid_done", done, 0);
        check_eq("rst_mid_ones", ones_cnt, 0);
        check_eq("rst_mid_sig", sig, 0);
        check_eq("rst_mid_rd", rd_data, 0);
        reset = 1'b0;
      end
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; start_g = 1'b0; abort_g = 1'b0;
    resp_zero = 1'b0; rd_addr = 4'd0; done_g_cyc = -1;
    tick; tick;
    check_eq("rst_pat", pat_out, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_ones", ones_cnt, 0);
    check_eq("rst_sig", sig, 0);
    check_eq("rst_rd", rd_data, 0);
    reset = 1'b0;
    tick;

    // full AND sweep on both instances; stray starts at cycle 5 and 49
    sweep(-1, -1, 1'b1, 1'b1, 1'b0, dc, dn);
    check_eq("a_done_cyc", dc, 49);
    check_eq("a_done_n", dn, 1);
    check_eq("a_busy_end", busy, 0);
    check_eq("a_ones", ones_cnt, 1);
    check_eq("a_sig", sig, 1);
    check_eq("a_pat_hold", pat_out, 15);
    check_eq("g_done_cyc", done_g_cyc, 33);
    check_eq("g_ones", ones_cnt_g, 1);
    check_eq("g_sig", sig_g, 32);
    for (int a = 0; a < 16; a++) begin
      rd_addr = 4'(a);
      tick;
      check_eq($sformatf("a_mem%0d", a), rd_data, (a == 15) ? 1 : 0);
      check_eq($sformatf("g_mem%0d", a), rd_data_g, (a == 15) ? 1 : 0);
    end

    // zero response sweep, with read-during-write on address 15
    resp_zero = 1'b1;
    rd_addr   = 4'd15;
    sweep(-1, -1, 1'b0, 1'b0, 1'b1, dc, dn);
    check_eq("z_done_cyc", dc, 49);
    check_eq("z_ones", ones_cnt, 0);
    check_eq("z_sig", sig, 0);
    resp_zero = 1'b0;

    // abort in the SAMPLE cycle of pattern 15: write must be dropped
    sweep(48, -1, 1'b0, 1'b0, 1'b0, dc, dn);
    check_eq("s_done_n", dn, 0);
    check_eq("s_ones", ones_cnt, 0);
    check_eq("s_sig", sig, 0);
    check_eq("s_pat", pat_out, 15);
    tick;
    check_eq("s_mem15", rd_data, 0);

    // abort in cycle 10, then a fresh complete sweep
    sweep(10, -1, 1'b0, 1'b0, 1'b0, dc, dn);
    check_eq("b_done_n", dn, 0);
    check_eq("b_pat", pat_out, 3);
    sweep(-1, -1, 1'b0, 1'b0, 1'b0, dc, dn);
    check_eq("c_done_cyc", dc, 49);
    check_eq("c_done_n", dn, 1);
    check_eq("c_ones", ones_cnt, 1);
    check_eq("c_sig", sig, 1);
    tick;
    check_eq("c_mem15", rd_data, 1);

    // reset in cycle 20
    sweep(-1, 20, 1'b0, 1'b0, 1'b0, dc, dn);
    check_eq("r_done_n", dn, 0);
    check_eq("r_busy_end", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
